sccb_init_sequencer: RTL

Parametrised successor to the fixed SCCB clock divider and COM7/COM15 write FSM in the camera top level. It generates the SCCB bit clock from `Clk` with a programmable divider and walks a register table, issuing one 3-phase write per entry to the SCCB master. Table entries can also encode delays and an early end marker. Writes that are NACKed or time out are retried, and per-run status is reported. It sits between the top level and `SCCB_master`, and runs once after camera reset or whenever `start` is pulsed.

---
 rtl/sccb_init_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sccb_init_sequencer.sv
// SCCB bit-clock divider plus table-driven register init sequencer with
// delay/end-marker entries, NACK/timeout retry and per-run status.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start after reset
// FETCH    | table index presented, ROM read in flight
// DECODE   | classify entry: end, delay or register write
// ISSUE    | raise write request, arm timeout
// WAIT_ACK | write request held, waiting for completion or timeout
// WAIT_REL | waiting for master to drop complete
// DELAY    | counting down delay ticks
// DONE     | run finished cleanly
// ERROR    | run aborted after exhausting retries
module sccb_init_sequencer #(
  parameter int CLK_DIV       = 64,
  parameter int NUM_REGS      = 16,
  parameter int IDX_W         = $clog2(NUM_REGS + 1),
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 64,
  parameter int DELAY_UNIT    = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic             sccb_clk,
  output logic             sccb_tick,
  output logic [7:0]       sccb_addr,
  output logic [7:0]       sccb_data,
  output logic             sccb_w3,
  input  logic             sccb_complete,
  input  logic             sccb_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] wr_count
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DLY_W = 8 + $clog2(DELAY_UNIT);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ACK,
    S_WAIT_REL, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [RTY_W-1:0] retry;
  logic [TO_W-1:0]  to_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic             cmp_d;
  logic             cmp_rise;

  assign tbl_addr = idx;
  assign cmp_rise = sccb_complete & ~cmp_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_cnt   <= '0;
      sccb_clk  <= 1'b0;
      sccb_tick <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt   <= '0;
      sccb_clk  <= ~sccb_clk;
      sccb_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      sccb_tick <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      retry     <= '0;
      to_cnt    <= '0;
      dly_cnt   <= '0;
      cmp_d     <= 1'b0;
      sccb_addr <= '0;
      sccb_data <= '0;
      sccb_w3   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_idx   <= '0;
      wr_count  <= '0;
    end else begin
      cmp_d <= sccb_complete;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            idx      <= '0;
            retry    <= '0;
            wr_count <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (idx == IDX_W'(NUM_REGS) || tbl_data == 16'hFFFF) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tbl_data[15:8] == 8'hFE) begin
            dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
            state   <= S_DELAY;
          end else begin
            sccb_addr <= tbl_data[15:8];
            sccb_data <= tbl_data[7:0];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sccb_w3 <= 1'b1;
          to_cnt  <= TO_W'(TIMEOUT_TICKS);
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A completion wins over a timeout landing in the same cycle.
          if (cmp_rise && !sccb_nack) begin
            sccb_w3  <= 1'b0;
            wr_count <= wr_count + 1'b1;
            idx      <= idx + 1'b1;
            retry    <= '0;
            state    <= S_WAIT_REL;
          end else if (cmp_rise || to_cnt == '0) begin
            sccb_w3 <= 1'b0;
            if (retry == RTY_W'(MAX_RETRY)) begin
              err_idx <= idx;
              error   <= 1'b1;
              busy    <= 1'b0;
              state   <= S_ERROR;
            end else begin
              retry <= retry + 1'b1;
              // A timed-out master never raised complete, so no release wait.
              state <= cmp_rise ? S_WAIT_REL : S_ISSUE;
            end
          end else if (sccb_tick) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (!sccb_complete) state <= (retry != '0) ? S_ISSUE : S_FETCH;
        end
        S_DELAY: begin
          if (dly_cnt == '0) begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end else if (sccb_tick) begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
